// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes of a 128-bit state per
// busy cycle through a shared inverse S-box, then holds the result until it is taken.
module inv_sub_bytes_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam int N       = 16 / BYTES_PER_CYCLE;
    localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int CHUNK_W = 8 * BYTES_PER_CYCLE;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bytes_per_cycle
            $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       work_q, work_d;
    logic [CHUNK_W-1:0] chunk_in, chunk_out;

    // Only BYTES_PER_CYCLE table instances: the counter steers which chunk they see.
    assign chunk_in = work_q[int'(cnt_q) * CHUNK_W +: CHUNK_W];

    generate
        for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
            assign chunk_out[8*b +: 8] = INV_SBOX[chunk_in[8*b +: 8]];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                work_d[int'(cnt_q) * CHUNK_W +: CHUNK_W] = chunk_out;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // Retiring the result and accepting the next state share one edge.
                if (out_ready) begin
                    if (in_valid) begin
                        work_d  = in_state;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign out_state = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: three instances (4, 1 and 16 bytes per cycle) checked
// against an inverse S-box derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_state  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_sub_bytes_iter #(
            .BYTES_PER_CYCLE((g == 0) ? 4 : (g == 1) ? 1 : 16)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_state (in_state[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_state(out_state[g])
        );
    end

    function automatic int n_of(input int d);
        return (d == 0) ? 4 : (d == 1) ? 16 : 1;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            b = {1'b0, b[7:1]};
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] w = {b, b};
        return w[15-n -: 8];
    endfunction

    // Forward S-box = affine(GF inverse); the inverse table is filled by inverting it.
    task automatic build_model();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Sends one state to instance d, holds off out_ready for hold cycles, then retires it.
    task automatic send_and_check(input int d, input logic [127:0] st, input logic [127:0] exp,
                                  input int hold, input string name);
        int w = 0;
        int lat = 0;
        in_state[d]  = st;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b0;
        #1;
        while (!in_ready[d] && w < 50) begin
            @(negedge clk); #1; w++;
        end
        n_checks++;
        if (!in_ready[d]) begin
            n_fail++;
            $display("FAIL %s accept_timeout: in_ready=%b required 1", name, in_ready[d]);
        end
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_state[d] = rand128();
        while (!out_valid[d] && lat < 40) begin
            @(negedge clk); lat++;
        end
        n_checks++;
        if (lat !== n_of(d)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, n_of(d));
        end
        n_checks++;
        if (out_state[d] !== exp) begin
            n_fail++;
            $display("FAIL %s data: got %h required %h", name, out_state[d], exp);
        end
        repeat (hold) begin
            @(negedge clk);
            in_state[d] = rand128();
            n_checks++;
            if (out_valid[d] !== 1'b1 || out_state[d] !== exp) begin
                n_fail++;
                $display("FAIL %s hold: out_valid=%b out_state=%h required 1 %h",
                         name, out_valid[d], out_state[d], exp);
            end
        end
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        n_checks++;
        if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s retire: out_valid=%b in_ready=%b required 0 1",
                     name, out_valid[d], in_ready[d]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b1;
            in_state[d]  = rand128();
            out_ready[d] = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || out_state[d] !== 128'h0) begin
                    n_fail++;
                    $display("FAIL reset_state[%0d]: out_valid=%b in_ready=%b out_state=%h required 0 1 0",
                             d, out_valid[d], in_ready[d], out_state[d]);
                end
            end
        end
        for (int d = 0; d < 3; d++) in_valid[d] = 1'b0;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_no_accept[%0d]: out_valid=%b in_ready=%b required 0 1",
                             d, out_valid[d], in_ready[d]);
                end
            end
        end
    endtask

    task automatic test_uniform();
        send_and_check(0, {16{8'h63}}, 128'h0, 0, "uniform_63");
    endtask

    task automatic test_mixed();
        logic [127:0] st  = 128'h16ed7c63_16ed7c63_16ed7c63_16ed7c63;
        logic [127:0] exp = 128'hff530100_ff530100_ff530100_ff530100;
        send_and_check(0, st, exp, 1, "mixed_b4");
        send_and_check(1, st, exp, 1, "mixed_b1");
        send_and_check(2, st, exp, 1, "mixed_b16");
    endtask

    task automatic test_random();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 5; k++) begin
                logic [127:0] st = rand128();
                send_and_check(d, st, model(st), $urandom_range(0, 3), "random");
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] st  = rand128();
        logic [127:0] exp = model(st);
        int w = 0;
        in_state[0]  = st;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        while (!out_valid[0] && w < 40) begin
            @(negedge clk); w++;
        end
        for (int c = 0; c < 10; c++) begin
            in_state[0] = rand128();
            @(negedge clk);
            n_checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_state[0] !== exp) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: out_valid=%b in_ready=%b out_state=%h required 1 0 %h",
                         c, out_valid[0], in_ready[0], out_state[0], exp);
            end
        end
        out_ready[0] = 1'b1;
        #1;
        n_checks++;
        if (in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_in_ready_comb: got %b required 1", in_ready[0]);
        end
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure_single_transfer[%0d]: out_valid=%b in_ready=%b required 0 1",
                         c, out_valid[0], in_ready[0]);
            end
            @(negedge clk);
        end
        out_ready[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] items [4];
        logic [127:0] exp_q [$];
        logic [127:0] e;
        int idx = 0;
        int got = 0;
        int cyc = 0;
        int last_cyc = -1;
        bit acc;
        items[0] = {16{8'h63}};
        items[1] = {16{8'h7c}};
        items[2] = {16{8'h52}};
        items[3] = {16{8'h01}};
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_state[0]  = items[0];
        #1;
        acc = in_valid[0] && in_ready[0];
        if (acc) exp_q.push_back(model(in_state[0]));
        while (got < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 4) in_state[0] = items[idx];
                else begin
                    in_valid[0] = 1'b0;
                    in_state[0] = rand128();
                end
            end
            #1;
            if (out_valid[0]) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected_output: got %h required none", out_state[0]);
                end else begin
                    e = exp_q.pop_front();
                    if (out_state[0] !== e) begin
                        n_fail++;
                        $display("FAIL b2b_data[%0d]: got %h required %h", got, out_state[0], e);
                    end
                end
                if (last_cyc >= 0) begin
                    n_checks++;
                    if (cyc - last_cyc !== 5) begin
                        n_fail++;
                        $display("FAIL b2b_spacing[%0d]: got %0d required 5", got, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            acc = in_valid[0] && in_ready[0];
            if (acc) exp_q.push_back(model(in_state[0]));
        end
        n_checks++;
        if (got !== 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d required 4", got);
        end
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [127:0] st = rand128();
        int seen = 0;
        in_state[0] = st;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_state[0] !== 128'h0) begin
            n_fail++;
            $display("FAIL mid_reset_state: out_valid=%b in_ready=%b out_state=%h required 0 1 0",
                     out_valid[0], in_ready[0], out_state[0]);
        end
        repeat (20) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_discard: out_valid high %0d cycles required 0", seen);
        end
        out_ready[0] = 1'b0;
        st = rand128();
        send_and_check(0, st, model(st), 0, "after_mid_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_state[d]  = '0;
            out_ready[d] = 1'b0;
        end
        build_model();
        test_reset();
        test_uniform();
        test_mixed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
